fetch_redirect_ctrl: RTL and testbench

Control block on the driving end of the fetch stage's PC-redirect port. It generates `pc_write`, `pc_write_back_value` and `clear_instruction` from three sources: taken branches (execute), RET/RTI popped PCs (memory), and external interrupts. It sequences pipeline squash, interrupt drain, vector wait and return-address capture, so the fetch stage only loads the PC and inserts NOPs.

---
 rtl/fetch_redirect_ctrl.sv | 113 +++++++++++
 tb/tb_fetch_redirect_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/fetch_redirect_ctrl.sv
// fetch_redirect_ctrl: drives the fetch PC-redirect port (branch/RET squash, interrupt drain, vector wait).
// Interrupt path is present only when FETCH_REDIRECT_INT_EN is defined.
module fetch_redirect_ctrl #(
  parameter int FLUSH_CYCLES = 2,
  parameter int DRAIN_CYCLES = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] pc_plus_one_r,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        ret_valid,
  input  logic [31:0] ret_pc,
  input  logic        int_req,
  input  logic        int_vector_valid,
  input  logic [31:0] int_vector,
  output logic        pc_write,
  output logic [31:0] pc_write_back_value,
  output logic        clear_instruction,
  output logic        int_ack,
  output logic [31:0] int_ret_pc,
  output logic        busy
);
  typedef enum logic [1:0] {IDLE, FLUSH, INT_DRAIN, INT_WAIT} state_t;
  localparam logic [2:0] FLUSH_INIT = 3'(FLUSH_CYCLES - 1);
  localparam logic [2:0] DRAIN_INIT = 3'(DRAIN_CYCLES - 1);
  state_t state, state_n;
  logic [2:0] cnt, cnt_n;
  logic redir, accept, pc_write_n, int_ack_n;
  logic [31:0] tgt, value_n, ret_n;
  assign redir = ret_valid | branch_taken;
  assign tgt = ret_valid ? ret_pc : branch_target;
  assign busy = state != IDLE;
`ifdef FETCH_REDIRECT_INT_EN
  assign accept = state == IDLE && !redir && int_req && !stall;
`else
  logic unused_int;
  assign accept = 1'b0;
  assign unused_int = ^{int_req, int_vector_valid, int_vector, pc_plus_one_r, stall & accept};
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt <= '0;
      pc_write <= 1'b0;
      pc_write_back_value <= '0;
      clear_instruction <= 1'b1;
      int_ack <= 1'b0;
      int_ret_pc <= '0;
    end else begin
      state <= state_n;
      cnt <= cnt_n;
      pc_write <= pc_write_n;
      pc_write_back_value <= value_n;
      clear_instruction <= state_n != IDLE;
      int_ack <= int_ack_n;
      int_ret_pc <= ret_n;
    end
  end
  always_comb begin
    state_n = state;
    cnt_n = cnt;
    case (state)
      IDLE: begin
        if (redir) begin
          state_n = FLUSH;
          cnt_n = FLUSH_INIT;
        end else if (accept) begin
          state_n = INT_DRAIN;
          cnt_n = DRAIN_INIT;
        end
      end
      FLUSH: begin
        if (redir) cnt_n = FLUSH_INIT;
        else if (!stall) begin
          if (cnt == 3'd0) state_n = IDLE;
          else cnt_n = cnt - 3'd1;
        end
      end
`ifdef FETCH_REDIRECT_INT_EN
      INT_DRAIN: begin
        if (!stall) begin
          if (cnt == 3'd0) state_n = INT_WAIT;
          else cnt_n = cnt - 3'd1;
        end
      end
      INT_WAIT: begin
        if (int_vector_valid) begin
          state_n = FLUSH;
          cnt_n = FLUSH_INIT;
        end
      end
`endif
      default: state_n = IDLE;
    endcase
  end
  always_comb begin
    pc_write_n = redir && (state == IDLE || state == FLUSH);
    value_n = pc_write_n ? tgt : pc_write_back_value;
    int_ack_n = 1'b0;
    ret_n = '0;
`ifdef FETCH_REDIRECT_INT_EN
    int_ack_n = state == INT_DRAIN && !stall && cnt == 3'd0;
    // a redirect while draining retargets the return address instead of the PC
    ret_n = accept ? pc_plus_one_r - 32'd1 : (state == INT_DRAIN && redir) ? tgt : int_ret_pc;
    if (state == INT_WAIT && int_vector_valid) begin
      pc_write_n = 1'b1;
      value_n = int_vector;
    end
`endif
  end
endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// tb_fetch_redirect_ctrl: directed stimulus with a scoreboard of expected pc_write / int_ack events.
module tb_fetch_redirect_ctrl;
  logic clk = 1'b0, reset, stall, branch_taken, ret_valid, int_req, int_vector_valid;
  logic [31:0] pc_plus_one_r, branch_target, ret_pc, int_vector;
  logic pc_write, clear_instruction, int_ack, busy;
  logic [31:0] pc_write_back_value, int_ret_pc;
  int errors = 0, checks = 0;
  typedef struct {logic kind; logic [31:0] val;} exp_t;
  exp_t q[$];

  fetch_redirect_ctrl dut (
    .clk(clk), .reset(reset), .stall(stall), .pc_plus_one_r(pc_plus_one_r),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .ret_valid(ret_valid), .ret_pc(ret_pc), .int_req(int_req),
    .int_vector_valid(int_vector_valid), .int_vector(int_vector),
    .pc_write(pc_write), .pc_write_back_value(pc_write_back_value),
    .clear_instruction(clear_instruction), .int_ack(int_ack),
    .int_ret_pc(int_ret_pc), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input logic kind, input logic [31:0] val);
    exp_t e;
    e.kind = kind;
    e.val = val;
    q.push_back(e);
  endtask

  task automatic sb_check(input logic kind, input logic [31:0] act, input string name);
    exp_t e;
    checks++;
    if (q.size() == 0) begin
      errors++;
      $display("FAIL sb_%s: unexpected event value %h, expected none", name, act);
    end else begin
      e = q.pop_front();
      if (e.kind !== kind || e.val !== act) begin
        errors++;
        $display("FAIL sb_%s: got kind %0d value %h expected kind %0d value %h", name, kind, act, e.kind, e.val);
      end
    end
  endtask

  // monitor: every strobe from the DUT must match the next expected event
  always @(negedge clk) begin
    if (pc_write === 1'b1) sb_check(1'b0, pc_write_back_value, "pc_write");
    if (int_ack === 1'b1) sb_check(1'b1, int_ret_pc, "int_ack");
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_pc_write"}, 32'(pc_write), 32'd0);
    chk({tag, "_value"}, pc_write_back_value, 32'd0);
    chk({tag, "_clear"}, 32'(clear_instruction), 32'd1);
    chk({tag, "_int_ack"}, 32'(int_ack), 32'd0);
    chk({tag, "_int_ret_pc"}, int_ret_pc, 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; ret_valid = 1'b0; int_req = 1'b0;
    int_vector_valid = 1'b0; pc_plus_one_r = '0; branch_target = '0; ret_pc = '0; int_vector = '0;
    tick(3);
    check_reset_vals("rst");
    reset = 1'b1;
    tick(1);
    chk("rel_clear", 32'(clear_instruction), 32'd0);
    chk("rel_busy", 32'(busy), 32'd0);

    // plain branch
    branch_taken = 1'b1; branch_target = 32'h40; push(1'b0, 32'h40);
    tick(1);
    branch_taken = 1'b0;
    chk("br_pc_write", 32'(pc_write), 32'd1);
    chk("br_clear1", 32'(clear_instruction), 32'd1);
    chk("br_busy", 32'(busy), 32'd1);
    tick(1);
    chk("br_clear2", 32'(clear_instruction), 32'd1);
    tick(1);
    chk("br_clear3", 32'(clear_instruction), 32'd0);
    chk("br_hold", pc_write_back_value, 32'h40);

    // ret wins over branch
    ret_valid = 1'b1; ret_pc = 32'h100; branch_taken = 1'b1; branch_target = 32'h40; push(1'b0, 32'h100);
    tick(1);
    ret_valid = 1'b0; branch_taken = 1'b0;
    tick(2);
    chk("ret_idle", 32'(busy), 32'd0);

    // restart during flush
    branch_taken = 1'b1; branch_target = 32'h40; push(1'b0, 32'h40);
    tick(1);
    branch_target = 32'h80; push(1'b0, 32'h80);
    tick(1);
    branch_taken = 1'b0;
    chk("rs_clear1", 32'(clear_instruction), 32'd1);
    tick(1);
    chk("rs_clear2", 32'(clear_instruction), 32'd1);
    tick(1);
    chk("rs_clear3", 32'(clear_instruction), 32'd0);

    // stall stretches flush by 3 cycles
    branch_taken = 1'b1; branch_target = 32'h44; push(1'b0, 32'h44);
    tick(1);
    branch_taken = 1'b0; stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i == 3) stall = 1'b0;
      chk($sformatf("st_clear%0d", i), 32'(clear_instruction), 32'd1);
      tick(1);
    end
    chk("st_clear_end", 32'(clear_instruction), 32'd0);

`ifdef FETCH_REDIRECT_INT_EN
    // stall blocks acceptance
    stall = 1'b1; int_req = 1'b1; pc_plus_one_r = 32'h25;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      chk($sformatf("blk_busy%0d", i), 32'(busy), 32'd0);
    end
    stall = 1'b0; push(1'b1, 32'h24);
    tick(1);
    chk("int_busy", 32'(busy), 32'd1);
    chk("int_clear", 32'(clear_instruction), 32'd1);
    chk("int_ret_pc", int_ret_pc, 32'h24);
    tick(2);
    chk("int_ack_early", 32'(int_ack), 32'd0);
    tick(1);
    chk("int_ack_time", 32'(int_ack), 32'd1);
    int_req = 1'b0;
    branch_taken = 1'b1; branch_target = 32'h99;
    tick(1);
    branch_taken = 1'b0;
    chk("wait_busy", 32'(busy), 32'd1);
    chk("wait_value", pc_write_back_value, 32'h44);
    int_vector_valid = 1'b1; int_vector = 32'h200; push(1'b0, 32'h200);
    tick(1);
    int_vector_valid = 1'b0;
    chk("vec_pc_write", 32'(pc_write), 32'd1);
    chk("vec_clear1", 32'(clear_instruction), 32'd1);
    tick(1);
    chk("vec_clear2", 32'(clear_instruction), 32'd1);
    tick(1);
    chk("vec_clear3", 32'(clear_instruction), 32'd0);

    // redirect during drain retargets return address
    int_req = 1'b1; pc_plus_one_r = 32'h31;
    tick(1);
    int_req = 1'b0;
    chk("dr_ret0", int_ret_pc, 32'h30);
    branch_taken = 1'b1; branch_target = 32'h60; push(1'b1, 32'h60);
    tick(1);
    branch_taken = 1'b0;
    chk("dr_ret1", int_ret_pc, 32'h60);
    tick(2);
    chk("dr_ack", 32'(int_ack), 32'd1);
    int_vector_valid = 1'b1; int_vector = 32'h300; push(1'b0, 32'h300);
    tick(1);
    int_vector_valid = 1'b0;
    tick(2);

    // reset during INT_WAIT aborts
    int_req = 1'b1; pc_plus_one_r = 32'h11; push(1'b1, 32'h10);
    tick(1);
    int_req = 1'b0;
    tick(3);
    chk("ab_ack", 32'(int_ack), 32'd1);
    reset = 1'b0; int_vector_valid = 1'b1; int_vector = 32'h400;
    tick(1);
    check_reset_vals("ab");
    int_vector_valid = 1'b0; reset = 1'b1;
    tick(4);
    chk("ab_busy", 32'(busy), 32'd0);
    chk("ab_ret", int_ret_pc, 32'd0);
`else
    // interrupt inputs have no effect
    int_req = 1'b1; pc_plus_one_r = 32'h25; int_vector_valid = 1'b1; int_vector = 32'h200;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      chk($sformatf("noint_busy%0d", i), 32'(busy), 32'd0);
      chk($sformatf("noint_ret%0d", i), int_ret_pc, 32'd0);
      chk($sformatf("noint_ack%0d", i), 32'(int_ack), 32'd0);
    end
    int_req = 1'b0; int_vector_valid = 1'b0;
    ret_valid = 1'b1; ret_pc = 32'h120; push(1'b0, 32'h120);
    tick(1);
    ret_valid = 1'b0;
    chk("noint_br_clear", 32'(clear_instruction), 32'd1);
    tick(2);
    chk("noint_br_idle", 32'(busy), 32'd0);
`endif
    tick(2);
    chk("sb_empty", 32'(q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
